// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - Default byte width and line settings shared with uart_tx/uart_rx.
//   - State encoding for the uart_tx_sched scheduler FSM.
package uart_pkg;

    localparam int UART_N    = 8;
    localparam int BAUD_RATE = 115200;
    localparam int CLK_FREQ  = 50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Searches req upward from ptr with wrap and returns the first set bit.
//   req   in  NREQ  request vector
//   ptr   in  PW    highest-priority index
//   gnt   out NREQ  one-hot winner (all zero when no request)
//   idx   out PW    index of the winner
//   valid out 1     any request present
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 2) ? 2 : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    int unsigned   c;
    logic [PW-1:0] ci;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        ci    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            c  = (32'(ptr) + k) % NREQ;
            ci = c[PW-1:0];
            if (!valid && req[ci]) begin
                gnt[ci] = 1'b1;
                idx     = ci;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx between NREQ
// byte-stream requesters. A requester owns the transmitter for a whole
// packet (bytes up to and including one flagged last); each byte is issued
// as a one-cycle start_tx pulse and then tracked through tx_busy.
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   NREQ    per-requester byte valid
//   req_data   in   NREQ*N  per-requester byte, requester i at [i*N +: N]
//   req_last   in   NREQ    last byte of packet, qualified by req_valid
//   req_ready  out  NREQ    byte accept (combinational)
//   grant      out  NREQ    one-hot current owner
//   start_tx   out  1       start pulse to uart_tx
//   data_in    out  N       byte to uart_tx
//   tx_busy    in   1       busy from uart_tx
//   sched_busy out  1       scheduler not idle
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int N       = UART_N,
    parameter  int NREQ    = 2,
    parameter  int BUSY_TO = 4,
    parameter  int HOLD_TO = 65535,
    localparam int PW      = (NREQ > 2) ? 2 : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*N-1:0] req_data,
    input  logic [NREQ-1:0] req_last,
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] grant,
    output logic            start_tx,
    output logic [N-1:0]    data_in,
    input  logic            tx_busy,
    output logic            sched_busy
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TO - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TO - 1);

    sched_state_t    state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   gidx, gidx_n, gidx_inc;
    logic [NREQ-1:0] grant_n;
    logic            last_r, last_n;
    logic [N-1:0]    data_n;
    logic [15:0]     hold_cnt, hold_n;
    logic [15:0]     busy_cnt, busy_n;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;

    logic            sel_valid, sel_last;
    logic [N-1:0]    sel_data;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Inputs of the current owner.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gidx == PW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*N +: N];
            end
        end
    end

    assign gidx_inc  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    assign req_ready = (state == ST_SEND) ? grant : '0;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gidx_n  = gidx;
        grant_n = grant;
        last_n  = last_r;
        data_n  = data_in;
        hold_n  = hold_cnt;
        busy_n  = busy_cnt;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_n = arb_gnt;
                    gidx_n  = arb_idx;
                    hold_n  = '0;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sel_valid) begin
                    data_n  = sel_data;
                    last_n  = sel_last;
                    hold_n  = '0;
                    state_n = ST_START;
                end else if (hold_cnt == HOLD_LAST) begin
                    grant_n = '0;
                    ptr_n   = gidx_inc;
                    hold_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    hold_n = hold_cnt + 16'd1;
                end
            end
            ST_START: begin
                busy_n  = '0;
                state_n = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // Timeout compares the incremented count, so WAIT_LO is
                // entered BUSY_TO cycles after the start_tx pulse.
                if (tx_busy || (busy_cnt + 16'd1 == BUSY_LAST)) begin
                    state_n = ST_WAIT_LO;
                end else begin
                    busy_n = busy_cnt + 16'd1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_r) begin
                        grant_n = '0;
                        ptr_n   = gidx_inc;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_SEND;
                    end
                end
            end
            default: begin
                grant_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            gidx       <= '0;
            grant      <= '0;
            last_r     <= 1'b0;
            data_in    <= '0;
            hold_cnt   <= '0;
            busy_cnt   <= '0;
            start_tx   <= 1'b0;
            sched_busy <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            gidx       <= gidx_n;
            grant      <= grant_n;
            last_r     <= last_n;
            data_in    <= data_n;
            hold_cnt   <= hold_n;
            busy_cnt   <= busy_n;
            start_tx   <= (state_n == ST_START);
            sched_busy <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: stimulus pushes expected {requester, byte}
// entries into a scoreboard queue; a monitor pops one per start_tx pulse.
module tb_uart_tx_sched;

    localparam int N       = 8;
    localparam int NREQ    = 2;
    localparam int BUSY_TO = 4;
    localparam int HOLD_TO = 8;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        start_tx;
    logic [7:0]  data_in;
    logic        tx_busy;
    logic        sched_busy;

    int   tests;
    int   fails;
    int   cyc;
    int   mptr;
    int   busy_mode;
    int   busy_len;
    bit   use_gaps;
    int   gap [2];
    exp_t exp_q[$];
    int   start_cyc[$];
    logic [8:0] pq0[$];
    logic [8:0] pq1[$];

    uart_tx_sched #(
        .N       (N),
        .NREQ    (NREQ),
        .BUSY_TO (BUSY_TO),
        .HOLD_TO (HOLD_TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .start_tx   (start_tx),
        .data_in    (data_in),
        .tx_busy    (tx_busy),
        .sched_busy (sched_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pq_size(input int i);
        return (i == 0) ? pq0.size() : pq1.size();
    endfunction

    function automatic logic [8:0] pq_at(input int i, input int j);
        return (i == 0) ? pq0[j] : pq1[j];
    endfunction

    task automatic pq_pop(input int i);
        if (i == 0) void'(pq0.pop_front());
        else        void'(pq1.pop_front());
    endtask

    // Reference order: whole packets granted round-robin among requesters
    // that still have packets, starting from mptr.
    task automatic push_model();
        int         pos [2];
        int         c;
        bit         found;
        bit         more;
        exp_t       e;
        logic [8:0] w;
        pos[0] = 0;
        pos[1] = 0;
        more   = 1'b1;
        while (more) begin
            found = 1'b0;
            for (int k = 0; k < 2; k++) begin
                c = (mptr + k) % 2;
                if (!found && pos[c] < pq_size(c)) begin
                    found = 1'b1;
                    do begin
                        w = pq_at(c, pos[c]);
                        pos[c]++;
                        e.src  = c;
                        e.data = w[7:0];
                        exp_q.push_back(e);
                    end while (!w[8] && pos[c] < pq_size(c));
                    mptr = (c + 1) % 2;
                end
            end
            more = found;
        end
    endtask

    task automatic present();
        logic [8:0] w;
        for (int i = 0; i < 2; i++) begin
            if (gap[i] > 0) begin
                req_valid[i] = 1'b0;
                gap[i]--;
            end else if (pq_size(i) > 0) begin
                w = pq_at(i, 0);
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = w[7:0];
                req_last[i]        = w[8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic run_stream(input string name, input int budget);
        int         c;
        logic [1:0] acc;
        logic [8:0] f;
        c      = 0;
        gap[0] = 0;
        gap[1] = 0;
        present();
        while ((pq_size(0) > 0 || pq_size(1) > 0 || sched_busy) && c < budget) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            c++;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    f = pq_at(i, 0);
                    pq_pop(i);
                    if (!f[8] && use_gaps) gap[i] = $urandom_range(0, 4);
                end
            end
            present();
        end
        chk({name, "_done"}, 32'(c < budget), 1);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while (sched_busy && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, 32'(sched_busy), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset && start_tx) begin
                start_cyc.push_back(cyc);
                chk("start_vs_busy", 32'(tx_busy), 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: start_tx with data_in=%0h, no byte expected", data_in);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(data_in), 32'(e.data));
                    chk("sb_grant", 32'(grant), 32'(1) << e.src);
                end
            end
        end
    endtask

    // uart_tx stand-in: busy rises 1-2 cycles after start_tx and holds.
    task automatic uart_model();
        int n;
        forever begin
            @(negedge clk);
            if (!reset && start_tx && busy_mode == 0) begin
                @(posedge clk);
                #1;
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                end
                tx_busy = 1'b1;
                n = (busy_len != 0) ? busy_len : int'($urandom_range(1, 8));
                repeat (n) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    endtask

    initial begin
        int         bad;
        int         c;
        int         d1;
        int         d2;
        int         npk;
        int         len;
        logic [7:0] b;

        tests     = 0;
        fails     = 0;
        cyc       = 0;
        mptr      = 0;
        busy_mode = 0;
        busy_len  = 0;
        use_gaps  = 1'b0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;

        fork
            monitor();
            uart_model();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst0_grant", 32'(grant), 0);
        chk("rst0_start", 32'(start_tx), 0);
        chk("rst0_data", 32'(data_in), 0);
        chk("rst0_sbusy", 32'(sched_busy), 0);
        chk("rst0_ready", 32'(req_ready), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Packet atomicity: A1,A2 complete before B1
        pq0 = '{9'h0A1, 9'h1A2};
        pq1 = '{9'h1B1};
        mptr = 0;
        push_model();
        run_stream("atomic", 300);

        // Round-robin between continuous single-byte requesters
        for (int i = 0; i < 3; i++) begin
            pq0.push_back(9'h111);
            pq1.push_back(9'h122);
        end
        push_model();
        run_stream("rr", 500);

        // Single requester, single byte: start_tx two cycles after valid
        busy_len = 4;
        req_valid = 2'b01;
        req_data[7:0] = 8'h55;
        req_last = 2'b01;
        exp_q.push_back('{0, 8'h55});
        @(posedge clk);
        #1;
        chk("t1_send_grant", 32'(grant), 1);
        chk("t1_send_ready", 32'(req_ready), 1);
        chk("t1_no_start", 32'(start_tx), 0);
        @(posedge clk);
        #1;
        chk("t1_start", 32'(start_tx), 1);
        chk("t1_data", 32'(data_in), 32'h55);
        req_valid = 2'b00;
        bad = 0;
        c = 0;
        while (sched_busy && c < 50) begin
            if (grant !== 2'b01) bad++;
            @(posedge clk);
            #1;
            c++;
        end
        chk("t1_grant_hold", bad, 0);
        chk("t1_idle", 32'(sched_busy), 0);
        chk("t1_grant_rel", 32'(grant), 0);
        mptr = 1;

        // Randomized packets with mid-packet valid gaps
        busy_len = 0;
        use_gaps = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2; i++) begin
                npk = $urandom_range(1, 4);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++) begin
                        b = 8'($urandom);
                        if (i == 0) pq0.push_back({(k == len - 1), b});
                        else        pq1.push_back({(k == len - 1), b});
                    end
                end
            end
            push_model();
            run_stream("rand", 3000);
        end
        use_gaps = 1'b0;

        // Hold timeout: owner drops valid mid-packet
        busy_len = 3;
        req_valid = 2'b01;
        req_data[7:0] = 8'h33;
        req_last = 2'b00;
        exp_q.push_back('{0, 8'h33});
        c = 0;
        while (grant !== 2'b01 && c < 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("hold_grant0", 32'(grant), 1);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        req_data[15:8] = 8'h44;
        req_last = 2'b10;
        exp_q.push_back('{1, 8'h44});
        c = 0;
        while (!req_ready[0] && c < 30) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("hold_send", 32'(req_ready[0]), 1);
        repeat (7) @(posedge clk);
        #1;
        chk("hold_still", 32'(grant), 1);
        @(posedge clk);
        #1;
        chk("hold_revoke", 32'(grant), 0);
        @(posedge clk);
        #1;
        chk("hold_next", 32'(grant), 2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle("hold_idle", 50);
        chk("hold_drain", exp_q.size(), 0);

        // Busy timeout: tx_busy never rises
        busy_mode = 1;
        pq0 = '{9'h061, 9'h062, 9'h163};
        push_model();
        start_cyc.delete();
        run_stream("bto", 300);
        chk("bto_starts", start_cyc.size(), 3);
        d1 = (start_cyc.size() >= 2) ? start_cyc[1] - start_cyc[0] : -1;
        d2 = (start_cyc.size() >= 3) ? start_cyc[2] - start_cyc[1] : -1;
        chk("bto_gap1", d1, 6);
        chk("bto_gap2", d2, 6);
        busy_mode = 0;

        // Async reset in WAIT_LO of a multi-byte packet from requester 1
        busy_len = 6;
        req_valid = 2'b10;
        req_data[15:8] = 8'h71;
        req_last = 2'b00;
        exp_q.push_back('{1, 8'h71});
        c = 0;
        while (!tx_busy && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("arst_busy_seen", 32'(tx_busy), 1);
        @(posedge clk);
        #1;
        #2;
        reset = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_start", 32'(start_tx), 0);
        chk("arst_data", 32'(data_in), 0);
        chk("arst_sbusy", 32'(sched_busy), 0);
        chk("arst_ready", 32'(req_ready), 0);
        c = 0;
        while (tx_busy && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("arst_busy_drop", 32'(tx_busy), 0);
        @(posedge clk);
        #1;
        pq0 = '{9'h181};
        pq1 = '{9'h182};
        mptr = 0;
        push_model();
        reset = 1'b0;
        run_stream("arst_rr", 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one uart_tx transmitter between NREQ byte-stream requesters.
- Grants the transmitter to one requester per packet, bytes delimited by a last flag, so bytes from different requesters are never interleaved.
- Sequences each byte into uart_tx: one-cycle start_tx pulse, then waits for busy to rise and fall.
- Sits between producer blocks (e.g. result formatter, debug/status source) and the single uart_tx instance.

Parameters:
- N, 8, data width per byte; must match uart_tx N.
- NREQ, 2, number of requesters, 2..4.
- BUSY_TO, 4, max cycles to wait for tx_busy to rise after the start_tx pulse.
- HOLD_TO, 65535, max idle cycles inside a granted packet before the grant is revoked; 16-bit counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*N  per-requester byte; requester i uses bits [i*N +: N].
- req_last  in  NREQ  per-requester last-byte-of-packet flag, qualified by req_valid.
- req_ready  out  NREQ  per-requester accept; a byte transfers when valid&ready.
- grant  out  NREQ  one-hot current owner; all zero when no owner.
- start_tx  out  1  one-cycle start pulse to uart_tx.
- data_in  out  N  byte to uart_tx.
- tx_busy  in  1  busy from uart_tx.
- sched_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state IDLE; grant, req_ready, start_tx, data_in, sched_busy all 0.
  - RR pointer 0; both counters 0.
- All outputs are registered except req_ready, which is combinational: (state==SEND) & grant[i].
- FSM states: IDLE, SEND, START, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req_valid: select the first set bit searching from ptr upward with wrap.
  - Set grant one-hot for the winner; go SEND next cycle.
  - After reset, index 0 has top priority.
- SEND:
  - On req_valid[g]: capture req_data[g] into data_in, capture req_last[g] into last_r, clear hold counter, go START.
  - If req_valid[g] is low: increment hold counter. When it reaches HOLD_TO-1, clear grant, set ptr=g+1 (mod NREQ), go IDLE.
- START:
  - start_tx=1 for exactly this cycle; go WAIT_HI with the busy counter cleared.
- WAIT_HI:
  - If tx_busy=1, go WAIT_LO.
  - Otherwise increment the busy counter; at BUSY_TO-1, go WAIT_LO anyway. This tolerates a uart_tx that drops busy early.
- WAIT_LO:
  - On tx_busy=0: if last_r, clear grant, set ptr=g+1 (mod NREQ), go IDLE; otherwise go SEND.
- data_in is held stable from the START cycle until WAIT_LO exits.
- Exactly one start_tx pulse per accepted byte. start_tx is never asserted while tx_busy=1.
- Latency, IDLE with a valid request to start_tx: 2 cycles (IDLE -> SEND -> START).
- Inter-byte gap within a packet: WAIT_LO exit -> SEND -> START, i.e. 2 cycles after busy falls.
- Fairness: ptr advances only on packet end or hold timeout. A requester that re-requests immediately loses to any other pending requester.
- Requests arriving while another requester owns the transmitter are ignored until IDLE; there is no preemption.
- Simultaneous requests in IDLE: RR order decides. A requester asserting valid in the same cycle it is released is not regranted if another is pending.
- req_last with single-byte packets: grant released after that one byte.
- Reset mid-byte:
  - start_tx and grant drop immediately.
  - uart_tx is reset by the same net, so no partial-frame recovery is needed.

Decomposition:
- Package uart_pkg: the FSM state encoding (3-bit localparams) and the default N, BAUD_RATE and CLK_FREQ shared with uart_tx/uart_rx.
- Sub-module rr_arbiter (NREQ): combinational request vector + ptr -> one-hot grant and a valid bit. Reused later by the rx-side dispatcher.

Test Plan:
- Single requester: req0 sends a 1-byte packet 0x55 with last=1. Expect start_tx 2 cycles after valid, data_in=0x55, grant=01 until busy falls, then grant=00 and sched_busy=0.
- Packet atomicity: req0 sends 0xA1,0xA2(last) while req1 holds 0xB1(last) valid throughout. Expect start_tx order A1, A2, B1, and grant never 10 during the A packet.
- Round-robin: both requesters continuously send 1-byte packets 0x11 (req0) and 0x22 (req1) for 6 packets. Expect an alternating sequence 11, 22, 11, 22, 11, 22.
- Busy timeout: model uart_tx with tx_busy stuck 0. Expect the FSM to reach WAIT_LO after BUSY_TO=4 cycles, and each byte takes exactly 6 cycles from start_tx to the next start_tx.
- Hold timeout: with HOLD_TO=8, req0 sends a non-last byte 0x33, then drops valid. Expect grant revoked 8 cycles into SEND, and a pending req1 granted next.
- Async reset: assert reset during WAIT_LO of a 3-byte packet. Expect all outputs 0 without a clock edge; after release, index 0 has priority again.
